// File: rtl/uart_pkg.sv
// Types and constants shared by the UART transmit arbiter and its helpers.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, HDR, DATA} arb_state_t;

  // MSB flag that marks a header byte carrying the client id.
  localparam logic HDR_MARK = 1'b1;

  // Minimum number of idle cycles between consecutive tx_req pulses.
  localparam int HOLDOFF_CYCLES = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester after last_id wins,
// wrapping around to client 0.
module rr_arbiter #(
  parameter int NUM_CLIENTS = 4,
  localparam int ID_W = $clog2(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [ID_W-1:0]        last_id,
  output logic [NUM_CLIENTS-1:0] gnt,
  output logic [ID_W-1:0]        gnt_id
);

  logic          hit_hi;
  logic          hit_any;
  logic [ID_W-1:0] lo_id;

  // Descending scan leaves the lowest matching index in each candidate.
  always_comb begin
    gnt_id  = '0;
    lo_id   = '0;
    hit_hi  = 1'b0;
    hit_any = 1'b0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      if (req[i] && (i > int'(last_id))) begin
        hit_hi = 1'b1;
        gnt_id = ID_W'(i);
      end
      if (req[i]) begin
        hit_any = 1'b1;
        lo_id   = ID_W'(i);
      end
    end
    if (!hit_hi) gnt_id = lo_id;
    gnt = hit_any ? (NUM_CLIENTS'(1) << gnt_id) : '0;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_CLIENTS byte streams: round-robin
// grants held for a whole frame (up to MAX_BURST bytes), optional id header.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int WIDTH       = 8,
  parameter bit USE_HEADER  = 1'b1,
  parameter int MAX_BURST   = 16,
  localparam int ID_W       = $clog2(NUM_CLIENTS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CLIENTS-1:0]       cli_valid,
  input  logic [NUM_CLIENTS*WIDTH-1:0] cli_data,
  input  logic [NUM_CLIENTS-1:0]       cli_last,
  output logic [NUM_CLIENTS-1:0]       cli_ready,
  output logic                         tx_req,
  output logic [WIDTH-1:0]             tx_din,
  input  logic                         tx_ready,
  output logic [ID_W-1:0]              grant_id,
  output logic                         busy
);

  localparam int BURST_W   = 8;
  localparam int HOLDOFF_W = $clog2(HOLDOFF_CYCLES + 1);

  arb_state_t           state, state_nxt;
  logic [ID_W-1:0]      grant_nxt, last_id, last_nxt, win_id;
  logic [NUM_CLIENTS-1:0] win_gnt;
  logic [BURST_W-1:0]   burst_cnt, burst_nxt;
  logic [HOLDOFF_W-1:0] holdoff, holdoff_nxt;
  logic                 issue_ok;
  logic [WIDTH-1:0]     hdr_byte, cli_byte;
  logic                 vld_p0, vld_p1;
  logic [WIDTH-1:0]     dat_p0, dat_p1;

  rr_arbiter #(.NUM_CLIENTS(NUM_CLIENTS)) u_rr (
    .req     (cli_valid),
    .last_id (last_id),
    .gnt     (win_gnt),
    .gnt_id  (win_id)
  );

  // holdoff keeps two quiet cycles after every pulse, covering the UART's
  // registered tx_ready lag.
  assign issue_ok = tx_ready && (holdoff == '0);
  assign cli_byte = cli_data[int'(grant_id)*WIDTH +: WIDTH];

  always_comb begin
    hdr_byte = '0;
    hdr_byte[WIDTH-1] = HDR_MARK;
    hdr_byte[ID_W-1:0] = grant_id;
  end

  // ---- stage p0: grant / issue decision ----
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    last_nxt  = last_id;
    burst_nxt = burst_cnt;
    vld_p0    = 1'b0;
    dat_p0    = dat_p1;
    cli_ready = '0;
    case (state)
      IDLE: begin
        if (|win_gnt) begin
          grant_nxt = win_id;
          burst_nxt = '0;
          state_nxt = USE_HEADER ? HDR : DATA;
        end
      end
      HDR: begin
        if (issue_ok) begin
          vld_p0    = 1'b1;
          dat_p0    = hdr_byte;
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (issue_ok && cli_valid[grant_id]) begin
          cli_ready[grant_id] = 1'b1;
          vld_p0    = 1'b1;
          dat_p0    = cli_byte;
          burst_nxt = burst_cnt + BURST_W'(1);
          // End of frame and burst limit together still release only once.
          if (cli_last[grant_id] || (burst_cnt == BURST_W'(MAX_BURST - 1))) begin
            last_nxt  = grant_id;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (vld_p0)
      holdoff_nxt = HOLDOFF_W'(HOLDOFF_CYCLES);
    else if (holdoff != '0)
      holdoff_nxt = holdoff - HOLDOFF_W'(1);
    else
      holdoff_nxt = '0;
  end

  // ---- stage p1: registered UART request ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_id  <= '0;
      last_id   <= ID_W'(NUM_CLIENTS - 1);
      burst_cnt <= '0;
      holdoff   <= '0;
      vld_p1    <= 1'b0;
      dat_p1    <= '0;
    end else begin
      state     <= state_nxt;
      grant_id  <= grant_nxt;
      last_id   <= last_nxt;
      burst_cnt <= burst_nxt;
      holdoff   <= holdoff_nxt;
      vld_p1    <= vld_p0;
      dat_p1    <= dat_p0;
    end
  end

  assign tx_req = vld_p1;
  assign tx_din = dat_p1;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: scripted client queues, captured tx
// byte stream compared against hand-written expected sequences.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  cli_valid;
  logic [31:0] cli_data;
  logic [3:0]  cli_last;
  logic [3:0]  cli_ready;
  logic        tx_req;
  logic [7:0]  tx_din;
  logic        tx_ready;
  logic [1:0]  grant_id;
  logic        busy;

  uart_tx_arbiter #(
    .NUM_CLIENTS(4), .WIDTH(8), .USE_HEADER(1'b1), .MAX_BURST(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cli_valid(cli_valid), .cli_data(cli_data),
    .cli_last(cli_last), .cli_ready(cli_ready), .tx_req(tx_req),
    .tx_din(tx_din), .tx_ready(tx_ready), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [8:0] cq [4][$];
  logic [7:0] obs [$];
  logic [7:0] exp_q [$];
  logic [3:0] acc;
  logic       rdy_prev;
  logic       rdy_mode;
  int         cyc = 0;
  int         gap = 100;
  int         vecs = 0;
  int         errs = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vecs++;
    assert (got === want) else begin
      errs++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, got, want);
    end
  endtask

  task automatic load(input int c, input logic [7:0] d, input logic l);
    cq[c].push_back({l, d});
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < 4; i++)
      if (cq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: retire accepted bytes, drive inputs, then sample mid-cycle.
  task automatic tick();
    @(negedge clk);
    rdy_prev = tx_ready;
    for (int i = 0; i < 4; i++)
      if (acc[i] && cq[i].size() != 0) void'(cq[i].pop_front());
    cyc++;
    tx_ready = rdy_mode ? (cyc % 5 != 0) : 1'b1;
    for (int i = 0; i < 4; i++) begin
      cli_valid[i] = (cq[i].size() != 0);
      cli_data[i*8 +: 8] = cli_valid[i] ? cq[i][0][7:0] : 8'h00;
      cli_last[i] = cli_valid[i] ? cq[i][0][8] : 1'b0;
    end
    #1;
    acc = cli_ready;
    if (cli_ready != 4'b0000) begin
      check("cli_ready_onehot", $onehot(cli_ready), 1);
      check("cli_ready_busy", busy, 1);
    end
    if (tx_req) begin
      obs.push_back(tx_din);
      check("tx_gap", gap >= 2, 1);
      check("tx_rdy_prev", rdy_prev, 1);
      gap = 0;
    end else begin
      gap++;
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) cq[i].delete();
    acc = '0;
    cli_valid = '0;
    cli_last = '0;
    cli_data = '0;
    #1;
    check("rst_tx_req", tx_req, 0);
    check("rst_tx_din", tx_din, 0);
    check("rst_cli_ready", cli_ready, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_busy", busy, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic run_idle(input string tag, input int max);
    int  n;
    logic done;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(all_empty() && !busy) && n < max);
    done = all_empty() && !busy;
    check({tag, "_done"}, done, 1);
    repeat (4) tick();
  endtask

  task automatic check_stream(input string tag, input logic [7:0] want[$]);
    logic [7:0] got;
    check({tag, "_len"}, obs.size(), want.size());
    for (int i = 0; i < want.size(); i++) begin
      got = (i < obs.size()) ? obs[i] : 8'hxx;
      check($sformatf("%s[%0d]", tag, i), got, want[i]);
    end
    obs.delete();
  endtask

  initial begin
    int n;
    tx_ready = 1'b1;
    rdy_mode = 1'b0;
    cli_valid = '0;
    cli_data = '0;
    cli_last = '0;
    acc = '0;
    rdy_prev = 1'b1;

    // single client 1, latency and ordering
    do_reset();
    load(1, 8'h10, 1'b0); load(1, 8'h11, 1'b0); load(1, 8'h12, 1'b1);
    tick();
    check("t1_busy_pre", busy, 0);
    tick();
    check("t1_busy", busy, 1);
    check("t1_grant", grant_id, 1);
    check("t1_no_req_yet", tx_req, 0);
    tick();
    check("t1_hdr_req", tx_req, 1);
    check("t1_hdr_din", tx_din, 8'h81);
    run_idle("t1", 100);
    exp_q = '{8'h81, 8'h10, 8'h11, 8'h12};
    check_stream("t1", exp_q);
    check("t1_busy_end", busy, 0);

    // all four clients at once, one byte each
    do_reset();
    for (int c = 0; c < 4; c++) load(c, 8'hA0 + 8'(c), 1'b1);
    run_idle("t2", 200);
    exp_q = '{8'h80, 8'hA0, 8'h81, 8'hA1, 8'h82, 8'hA2, 8'h83, 8'hA3};
    check_stream("t2", exp_q);

    // fairness between 0 and 3 with tx_ready gaps
    do_reset();
    rdy_mode = 1'b1;
    exp_q.delete();
    for (int f = 0; f < 4; f++) begin
      load(0, 8'(2*f), 1'b0);        load(0, 8'(2*f + 1), 1'b1);
      load(3, 8'h30 + 8'(2*f), 1'b0); load(3, 8'h31 + 8'(2*f), 1'b1);
      exp_q.push_back(8'h80); exp_q.push_back(8'(2*f)); exp_q.push_back(8'(2*f + 1));
      exp_q.push_back(8'h83); exp_q.push_back(8'h30 + 8'(2*f)); exp_q.push_back(8'h31 + 8'(2*f));
    end
    run_idle("t3", 600);
    rdy_mode = 1'b0;
    check_stream("t3", exp_q);

    // burst limit of 4 forces release of a 6-byte frame
    do_reset();
    for (int b = 0; b < 6; b++) load(2, 8'h20 + 8'(b), b == 5);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(busy && grant_id == 2'd2) && n < 20);
    check("t4_grant2", grant_id, 2);
    load(0, 8'h05, 1'b0); load(0, 8'h06, 1'b1);
    run_idle("t4", 300);
    exp_q = '{8'h82, 8'h20, 8'h21, 8'h22, 8'h23, 8'h80, 8'h05, 8'h06,
              8'h82, 8'h24, 8'h25};
    check_stream("t4", exp_q);

    // reset while the second data byte is on the wire
    do_reset();
    load(1, 8'h10, 1'b0); load(1, 8'h11, 1'b0); load(1, 8'h12, 1'b1);
    n = 0;
    do begin
      tick();
      n++;
    end while (obs.size() < 3 && n < 60);
    check("t6_mid_req", tx_req, 1);
    do_reset();
    exp_q = '{8'h81, 8'h10, 8'h11};
    check_stream("t6_pre", exp_q);
    repeat (6) tick();
    check("t6_quiet", obs.size(), 0);
    load(1, 8'h12, 1'b1);
    load(0, 8'h07, 1'b1);
    run_idle("t6", 200);
    exp_q = '{8'h80, 8'h07, 8'h81, 8'h12};
    check_stream("t6_post", exp_q);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
